// File: rtl/hog_pkg.sv
// Shared constants and scan-FSM state encoding for the HOG cell scan sequencer.
package hog_pkg;

  localparam int IMG_W      = 66;
  localparam int CELL_SIZE  = 8;
  localparam int CELLS_X    = 8;
  localparam int CELLS_Y    = 16;
  localparam int ROW_W      = 14;
  localparam int COL_W      = 7;
  localparam int IDX_W      = 7;
  localparam int ROW_STRIDE = CELL_SIZE * IMG_W;

  // Scan sequencer states; also exported on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_FINISH    = 2'd3
  } scan_state_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hog_cell_counter.sv
// Cell x/y position counter with incrementally maintained begin-row/begin-column
// offsets and a linear cell index. The row offset is built by repeated addition
// of the row stride, so no multiplier is needed.
module hog_cell_counter #(
  parameter int IMG_W     = hog_pkg::IMG_W,
  parameter int CELL_SIZE = hog_pkg::CELL_SIZE,
  parameter int CELLS_X   = hog_pkg::CELLS_X,
  parameter int CELLS_Y   = hog_pkg::CELLS_Y,
  parameter int ROW_W     = hog_pkg::ROW_W,
  parameter int COL_W     = hog_pkg::COL_W,
  parameter int IDX_W     = hog_pkg::IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [ROW_W-1:0] o_begin_row,
  output logic [COL_W-1:0] o_begin_col,
  output logic [IDX_W-1:0] o_cell_idx,
  output logic             o_last_in_row,
  output logic             o_last_in_frame
);

  localparam int X_W        = hog_pkg::cnt_w(CELLS_X);
  localparam int Y_W        = hog_pkg::cnt_w(CELLS_Y);
  localparam int ROW_STRIDE = CELL_SIZE * IMG_W;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [IDX_W-1:0] r_idx;

  // Clear takes priority over advance; advance steps one cell in raster order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_x   <= '0;
      r_y   <= '0;
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= r_idx + IDX_W'(1);
      if (o_last_in_row) begin
        r_x   <= '0;
        r_col <= '0;
        r_y   <= r_y + Y_W'(1);
        r_row <= r_row + ROW_W'(ROW_STRIDE);
      end else begin
        r_x   <= r_x + X_W'(1);
        r_col <= r_col + COL_W'(CELL_SIZE);
      end
    end
  end

  assign o_begin_row     = r_row;
  assign o_begin_col     = r_col;
  assign o_cell_idx      = r_idx;
  assign o_last_in_row   = (r_x == X_W'(CELLS_X - 1));
  assign o_last_in_frame = o_last_in_row && (r_y == Y_W'(CELLS_Y - 1));

endmodule

// File: rtl/hog_cell_scan_ctrl.sv
// HOG cell scan sequencer: walks a detection window cell by cell, offering each
// cell's begin-row/begin-column offsets to the pixel-address decoder and waiting
// for the histogram stage to finish the cell before moving on.
// Optional feature macro: HOG_SCAN_ROW_DONE_EN adds oROW_DONE, a one-cycle pulse
// after the last cell of every cell row completes.
//
// Handshake: oVALID is registered and, once high, holds together with stable
// oBEGIN_ROW/oBEGIN_COL/oCELL_IDX until a cycle with iREADY=1; that cycle is the
// single transfer and oVALID is low on the next cycle. oVALID never depends
// combinationally on iREADY. iABORT overrides everything.
module hog_cell_scan_ctrl
  import hog_pkg::scan_state_t;
  import hog_pkg::ST_IDLE;
  import hog_pkg::ST_ISSUE;
  import hog_pkg::ST_WAIT_DONE;
  import hog_pkg::ST_FINISH;
#(
  parameter int IMG_W     = hog_pkg::IMG_W,
  parameter int CELL_SIZE = hog_pkg::CELL_SIZE,
  parameter int CELLS_X   = hog_pkg::CELLS_X,
  parameter int CELLS_Y   = hog_pkg::CELLS_Y,
  parameter int ROW_W     = hog_pkg::ROW_W,
  parameter int COL_W     = hog_pkg::COL_W
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iSTART,
  input  logic             iABORT,
  input  logic             iREADY,
  input  logic             iCELL_DONE,
  output logic             oVALID,
  output logic [ROW_W-1:0] oBEGIN_ROW,
  output logic [COL_W-1:0] oBEGIN_COL,
  output logic [6:0]       oCELL_IDX,
  output logic             oBUSY,
  output logic             oFRAME_DONE,
`ifdef HOG_SCAN_ROW_DONE_EN
  output logic             oROW_DONE,
`endif
  output scan_state_t      oDBG_STATE
);

  // The largest row offset must fit the row-offset width without wrapping.
  if ((CELLS_Y - 1) * CELL_SIZE * IMG_W >= (1 << ROW_W)) begin : g_row_w_check
    $error("hog_cell_scan_ctrl: ROW_W too narrow for the last cell row offset");
  end
  if ((CELLS_X - 1) * CELL_SIZE >= (1 << COL_W)) begin : g_col_w_check
    $error("hog_cell_scan_ctrl: COL_W too narrow for the last cell column offset");
  end

  scan_state_t r_state;

  logic w_done_evt;
  logic w_row_end;
  logic w_frame_end;
  logic w_clear;
  logic w_advance;
  logic w_last_in_row;
  logic w_last_in_frame;

  // A cell completes only while waiting for it; a frame ends on the row end of the last row.
  assign w_done_evt  = (r_state == ST_WAIT_DONE) && iCELL_DONE && !iABORT;
  assign w_row_end   = w_done_evt && w_last_in_row;
  assign w_frame_end = w_row_end && w_last_in_frame;
  assign w_clear     = iABORT || ((r_state == ST_IDLE) && iSTART) || w_frame_end;
  assign w_advance   = w_done_evt && !w_frame_end;

  hog_cell_counter #(
    .IMG_W     (IMG_W),
    .CELL_SIZE (CELL_SIZE),
    .CELLS_X   (CELLS_X),
    .CELLS_Y   (CELLS_Y),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .IDX_W     (7)
  ) u_counter (
    .i_clk           (iCLK),
    .i_rst_n         (iRST_n),
    .i_clear         (w_clear),
    .i_advance       (w_advance),
    .o_begin_row     (oBEGIN_ROW),
    .o_begin_col     (oBEGIN_COL),
    .o_cell_idx      (oCELL_IDX),
    .o_last_in_row   (w_last_in_row),
    .o_last_in_frame (w_last_in_frame)
  );

  // Scan FSM with registered handshake, busy and completion-pulse outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= ST_IDLE;
      oVALID      <= 1'b0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
`ifdef HOG_SCAN_ROW_DONE_EN
      oROW_DONE   <= 1'b0;
`endif
    end else begin
      oFRAME_DONE <= 1'b0;
`ifdef HOG_SCAN_ROW_DONE_EN
      oROW_DONE   <= 1'b0;
`endif
      if (iABORT) begin
        r_state <= ST_IDLE;
        oVALID  <= 1'b0;
        oBUSY   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (iSTART) begin
              r_state <= ST_ISSUE;
              oVALID  <= 1'b1;
              oBUSY   <= 1'b1;
            end
          end
          ST_ISSUE: begin
            if (iREADY) begin
              r_state <= ST_WAIT_DONE;
              oVALID  <= 1'b0;
            end
          end
          ST_WAIT_DONE: begin
            if (iCELL_DONE) begin
`ifdef HOG_SCAN_ROW_DONE_EN
              oROW_DONE <= w_row_end;
`endif
              if (w_frame_end) begin
                r_state     <= ST_FINISH;
                oFRAME_DONE <= 1'b1;
              end else begin
                r_state <= ST_ISSUE;
                oVALID  <= 1'b1;
              end
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
            oBUSY   <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            oVALID  <= 1'b0;
            oBUSY   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oDBG_STATE = r_state;

endmodule
